// File: rtl/bp_be_pipe_fp_misc.sv
// Floating-point "misc" pipe: sign injection, min/max, compares, classify and
// raw moves for single (NaN-boxed) and double operands. Every op returns its
// result and flags exactly latency_p cycles after issue.
//
// Ports:
//   clk_i, reset_i      clock, synchronous active-high reset
//   v_i                 issue valid (no backpressure)
//   op_i                0 FSGNJ, 1 FSGNJN, 2 FSGNJX, 3 FMIN, 4 FMAX, 5 FEQ, 6 FLT,
//                       7 FLE, 8 FCLASS, 9 FMV.X, 10 FMV.F, 11-15 reserved (zero)
//   fmt_i               0 single, 1 double
//   rs1_i, rs2_i        source operands
//   poison_i            drop the op issued this cycle
//   flush_i             drop every in-flight op and this cycle's issue
//   v_o, result_o       result valid / result (zero while v_o is low)
//   fflags_o            {NV,DZ,OF,UF,NX}; only NV is ever set
module bp_be_pipe_fp_misc #(
  parameter int unsigned latency_p     = 2,  // legal range 1..4
  parameter int unsigned dword_width_p = 64
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     v_i,
  input  logic [3:0]               op_i,
  input  logic                     fmt_i,
  input  logic [dword_width_p-1:0] rs1_i,
  input  logic [dword_width_p-1:0] rs2_i,
  input  logic                     poison_i,
  input  logic                     flush_i,
  output logic                     v_o,
  output logic [dword_width_p-1:0] result_o,
  output logic [4:0]               fflags_o
);

  // Operand in a format-neutral shape: sign plus magnitude bits (single
  // magnitudes are zero-extended so one comparator serves both formats).
  typedef struct packed {
    logic        sign;
    logic [62:0] mag;
    logic        inf;
    logic        zero;
    logic        sub;
    logic        norm;
    logic        snan;
    logic        qnan;
  } fp_op_t;

  function automatic fp_op_t decode(input logic fmt, input logic [63:0] rs);
    fp_op_t      o;
    logic [31:0] s;
    logic        exp_ones;
    logic        exp_zero;
    logic        man_zero;
    logic        quiet;
    // A single operand without a valid NaN box reads as the canonical qNaN.
    s = (rs[63:32] == 32'hFFFF_FFFF) ? rs[31:0] : 32'h7FC0_0000;
    if (fmt) begin
      o.sign   = rs[63];
      o.mag    = rs[62:0];
      exp_ones = &rs[62:52];
      exp_zero = ~|rs[62:52];
      man_zero = ~|rs[51:0];
      quiet    = rs[51];
    end else begin
      o.sign   = s[31];
      o.mag    = {32'b0, s[30:0]};
      exp_ones = &s[30:23];
      exp_zero = ~|s[30:23];
      man_zero = ~|s[22:0];
      quiet    = s[22];
    end
    o.inf  = exp_ones & man_zero;
    o.zero = exp_zero & man_zero;
    o.sub  = exp_zero & ~man_zero;
    o.norm = ~exp_ones & ~exp_zero;
    o.snan = exp_ones & ~man_zero & ~quiet;
    o.qnan = exp_ones & quiet;
    return o;
  endfunction

  function automatic logic [63:0] box(input logic fmt, input logic sign, input logic [62:0] mag);
    return fmt ? {sign, mag} : {32'hFFFF_FFFF, sign, mag[30:0]};
  endfunction

  fp_op_t                   a, b;
  logic                     a_nan, b_nan, any_nan, any_snan;
  logic                     lt_raw, eq;
  logic                     issue;
  logic [dword_width_p-1:0] res;
  logic                     nv;

  always_comb begin
    a        = decode(fmt_i, rs1_i);
    b        = decode(fmt_i, rs2_i);
    a_nan    = a.snan | a.qnan;
    b_nan    = b.snan | b.qnan;
    any_nan  = a_nan | b_nan;
    any_snan = a.snan | b.snan;
    // Total order on non-NaN values with -0 below +0; FLT masks the zero pair.
    lt_raw   = (a.sign != b.sign) ? a.sign
             : (a.sign ? (a.mag > b.mag) : (a.mag < b.mag));
    eq       = (a.zero & b.zero) | ({a.sign, a.mag} == {b.sign, b.mag});
    res      = '0;
    nv       = 1'b0;
    case (op_i)
      4'd0: res = box(fmt_i, b.sign, a.mag);
      4'd1: res = box(fmt_i, ~b.sign, a.mag);
      4'd2: res = box(fmt_i, a.sign ^ b.sign, a.mag);
      4'd3, 4'd4: begin
        nv = any_snan;
        if (a_nan & b_nan) begin
          res = fmt_i ? 64'h7FF8_0000_0000_0000 : 64'hFFFF_FFFF_7FC0_0000;
        end else if (a_nan) begin
          res = box(fmt_i, b.sign, b.mag);
        end else if (b_nan) begin
          res = box(fmt_i, a.sign, a.mag);
        end else if (lt_raw ^ (op_i == 4'd4)) begin
          res = box(fmt_i, a.sign, a.mag);
        end else begin
          res = box(fmt_i, b.sign, b.mag);
        end
      end
      4'd5: begin
        nv  = any_snan;
        res = {63'b0, ~any_nan & eq};
      end
      4'd6: begin
        nv  = any_nan;
        res = {63'b0, ~any_nan & lt_raw & ~(a.zero & b.zero)};
      end
      4'd7: begin
        nv  = any_nan;
        res = {63'b0, ~any_nan & (lt_raw | eq)};
      end
      4'd8: res = {54'b0, a.qnan, a.snan,
                   ~a.sign & a.inf, ~a.sign & a.norm, ~a.sign & a.sub, ~a.sign & a.zero,
                   a.sign & a.zero, a.sign & a.sub, a.sign & a.norm, a.sign & a.inf};
      4'd9:  res = fmt_i ? rs1_i : {{32{rs1_i[31]}}, rs1_i[31:0]};
      4'd10: res = fmt_i ? rs1_i : {32'hFFFF_FFFF, rs1_i[31:0]};
      default: res = '0;
    endcase
  end

  assign issue = v_i & ~poison_i & ~flush_i;

  // Stage index 0 is the combinational result; index i+1 is register stage i.
  logic [latency_p-1:0]     valid_q;
  logic [dword_width_p-1:0] result_q [latency_p];
  logic [4:0]               fflags_q [latency_p];
  logic [latency_p:0]       stage_v;
  logic [dword_width_p-1:0] stage_r  [latency_p+1];
  logic [4:0]               stage_f  [latency_p+1];

  always_comb begin
    stage_v    = {valid_q, issue};
    stage_r[0] = res;
    stage_f[0] = {nv, 4'b0};
    for (int i = 0; i < latency_p; i++) begin
      stage_r[i+1] = result_q[i];
      stage_f[i+1] = fflags_q[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= '0;
      for (int i = 0; i < latency_p; i++) begin
        result_q[i] <= '0;
        fflags_q[i] <= '0;
      end
    end else begin
      valid_q <= flush_i ? '0 : stage_v[latency_p-1:0];
      for (int i = 0; i < latency_p; i++) begin
        if (stage_v[i]) begin
          result_q[i] <= stage_r[i];
          fflags_q[i] <= stage_f[i];
        end
      end
    end
  end

  assign v_o      = stage_v[latency_p];
  assign result_o = v_o ? stage_r[latency_p] : '0;
  assign fflags_o = v_o ? stage_f[latency_p] : '0;

endmodule

// File: tb/tb_bp_be_pipe_fp_misc.sv
// Drives one shared stimulus stream into four copies of the FP misc pipe
// (latency 1..4) and checks every output of every copy each cycle.
module tb_bp_be_pipe_fp_misc;

  localparam int NumLat = 4;
  localparam int MaxCyc = 1024;

  typedef struct packed {
    logic [63:0] r;
    logic [4:0]  f;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, v, fmt, poison, flush;
  logic [3:0]  op;
  logic [63:0] rs1, rs2;
  logic        dv [NumLat];
  logic [63:0] dr [NumLat];
  logic [4:0]  df [NumLat];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NumLat; g++) begin : g_dut
    bp_be_pipe_fp_misc #(
      .latency_p    (g + 1),
      .dword_width_p(64)
    ) u_dut (
      .clk_i   (clk),
      .reset_i (reset),
      .v_i     (v),
      .op_i    (op),
      .fmt_i   (fmt),
      .rs1_i   (rs1),
      .rs2_i   (rs2),
      .poison_i(poison),
      .flush_i (flush),
      .v_o     (dv[g]),
      .result_o(dr[g]),
      .fflags_o(df[g])
    );
  end

  // History of accepted ops, indexed by the clock edge that accepted them.
  bit          hv  [MaxCyc];
  logic [63:0] hr  [MaxCyc];
  logic [4:0]  hf  [MaxCyc];
  bit          hl  [MaxCyc];
  logic [63:0] hlr [MaxCyc];
  logic [4:0]  hlf [MaxCyc];
  int n = 0;
  int last_kill = 0;
  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  // ---------------- reference model ----------------
  function automatic logic [63:0] unb(input bit f, input logic [63:0] x);
    if (f) return x;
    return (x[63:32] == 32'hFFFFFFFF) ? {32'h0, x[31:0]} : 64'h7FC00000;
  endfunction

  function automatic bit e_ones(input bit f, input logic [63:0] x);
    return f ? (x[62:52] == 11'h7FF) : (x[30:23] == 8'hFF);
  endfunction

  function automatic bit e_zero(input bit f, input logic [63:0] x);
    return f ? (x[62:52] == 11'h0) : (x[30:23] == 8'h0);
  endfunction

  function automatic bit fr_zero(input bit f, input logic [63:0] x);
    return f ? (x[51:0] == 52'h0) : (x[22:0] == 23'h0);
  endfunction

  function automatic bit is_nan(input bit f, input logic [63:0] x);
    return e_ones(f, x) && !fr_zero(f, x);
  endfunction

  function automatic bit is_snan(input bit f, input logic [63:0] x);
    return is_nan(f, x) && !(f ? x[51] : x[22]);
  endfunction

  function automatic bit sgn(input bit f, input logic [63:0] x);
    return f ? x[63] : x[31];
  endfunction

  // Signed integer key whose ordering matches numeric ordering (+0 == -0).
  function automatic longint key(input bit f, input logic [63:0] x);
    longint m;
    m = f ? {1'b0, x[62:0]} : {33'b0, x[30:0]};
    return sgn(f, x) ? -m : m;
  endfunction

  function automatic logic [63:0] boxr(input bit f, input logic [63:0] x);
    return f ? x : {32'hFFFFFFFF, x[31:0]};
  endfunction

  function automatic exp_t model(input logic [3:0] iop, input bit f,
                                 input logic [63:0] x1, input logic [63:0] x2);
    exp_t        m;
    logic [63:0] a, b;
    bit          na, nb, sa, sb, s, a_first;
    longint      ka, kb;
    int          idx;
    a  = unb(f, x1);
    b  = unb(f, x2);
    na = is_nan(f, a);
    nb = is_nan(f, b);
    sa = sgn(f, a);
    sb = sgn(f, b);
    ka = key(f, a);
    kb = key(f, b);
    m.r = '0;
    m.f = '0;
    case (iop)
      4'd0, 4'd1, 4'd2: begin
        s = (iop == 4'd0) ? sb : (iop == 4'd1) ? !sb : (sa ^ sb);
        m.r = f ? {s, a[62:0]} : {32'hFFFFFFFF, s, a[30:0]};
      end
      4'd3, 4'd4: begin
        m.f[4] = is_snan(f, a) | is_snan(f, b);
        if (na && nb) m.r = f ? 64'h7FF8000000000000 : 64'hFFFFFFFF7FC00000;
        else if (na) m.r = boxr(f, b);
        else if (nb) m.r = boxr(f, a);
        else begin
          a_first = (ka < kb) || (ka == kb && sa);
          m.r = boxr(f, (a_first == (iop == 4'd3)) ? a : b);
        end
      end
      4'd5: begin
        m.f[4] = is_snan(f, a) | is_snan(f, b);
        m.r = {63'b0, !(na || nb) && (ka == kb)};
      end
      4'd6: begin
        m.f[4] = na | nb;
        m.r = {63'b0, !(na || nb) && (ka < kb)};
      end
      4'd7: begin
        m.f[4] = na | nb;
        m.r = {63'b0, !(na || nb) && (ka <= kb)};
      end
      4'd8: begin
        if (na) idx = is_snan(f, a) ? 8 : 9;
        else if (e_ones(f, a)) idx = sa ? 0 : 7;
        else if (e_zero(f, a) && fr_zero(f, a)) idx = sa ? 3 : 4;
        else if (e_zero(f, a)) idx = sa ? 2 : 5;
        else idx = sa ? 1 : 6;
        m.r = 64'd1 << idx;
      end
      4'd9:  m.r = f ? x1 : {{32{x1[31]}}, x1[31:0]};
      4'd10: m.r = f ? x1 : {32'hFFFFFFFF, x1[31:0]};
      default: m.r = '0;
    endcase
    return m;
  endfunction

  function automatic logic [63:0] rand_opnd(input bit f);
    logic [31:0] s;
    if (f) begin
      case ($urandom_range(0, 13))
        0: return 64'h0000000000000000;
        1: return 64'h8000000000000000;
        2: return 64'h7FF0000000000000;
        3: return 64'hFFF0000000000000;
        4: return 64'h7FF8000000000000;
        5: return 64'h7FF0000000000001;
        6: return 64'hFFF4000000000000;
        7: return 64'h0000000000000001;
        8: return 64'h3FF0000000000000;
        9: return 64'hC000000000000000;
        default: return {$urandom, $urandom};
      endcase
    end
    case ($urandom_range(0, 13))
      0: s = 32'h00000000;
      1: s = 32'h80000000;
      2: s = 32'h7F800000;
      3: s = 32'hFF800000;
      4: s = 32'h7FC00000;
      5: s = 32'h7F800001;
      6: s = 32'hFFA00000;
      7: s = 32'h80000001;
      8: s = 32'h3F800000;
      9: s = 32'hC0000000;
      default: s = $urandom;
    endcase
    return ($urandom_range(0, 7) == 0) ? {$urandom, s} : {32'hFFFFFFFF, s};
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input int lat, input logic [63:0] obs,
                     input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s lat=%0d cyc=%0d got=%h want=%h", tag, lat, n, obs, expv);
    end
  endtask

  task automatic cycle(input bit iv, input bit ip, input bit ifl, input bit irst,
                       input logic [3:0] iop, input bit ifmt,
                       input logic [63:0] a, input logic [63:0] b,
                       input bit lit, input logic [63:0] lr, input logic [4:0] lf);
    exp_t m;
    v      = iv;
    poison = ip;
    flush  = ifl;
    reset  = irst;
    op     = iop;
    fmt    = ifmt;
    rs1    = a;
    rs2    = b;
    m      = model(iop, ifmt, a, b);
    @(posedge clk);
    n++;
    hv[n]  = iv && !ip && !ifl && !irst;
    hr[n]  = m.r;
    hf[n]  = m.f;
    hl[n]  = lit;
    hlr[n] = lr;
    hlf[n] = lf;
    if (irst || ifl) last_kill = n;
    #1;
    for (int k = 0; k < NumLat; k++) begin
      int e;
      bit ev;
      e  = n - k;  // edge that accepted the op now due at latency k+1
      ev = 1'b0;
      if (e >= 1) ev = hv[e] && (last_kill <= e);
      chk("v_o", k + 1, {63'b0, dv[k]}, {63'b0, ev});
      chk("result_o", k + 1, dr[k], ev ? hr[e] : 64'b0);
      chk("fflags_o", k + 1, {59'b0, df[k]}, ev ? {59'b0, hf[e]} : 64'b0);
      if (ev && hl[e]) begin
        chk("directed_result", k + 1, dr[k], hlr[e]);
        chk("directed_fflags", k + 1, {59'b0, df[k]}, {59'b0, hlf[e]});
      end
    end
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 4'd0, 1'b1, 64'h0, 64'h0, 0, 64'h0, 5'h0);
  endtask

  task automatic issue(input logic [3:0] iop, input bit ifmt, input logic [63:0] a,
                       input logic [63:0] b);
    cycle(1, 0, 0, 0, iop, ifmt, a, b, 0, 64'h0, 5'h0);
  endtask

  task automatic issue_lit(input logic [3:0] iop, input bit ifmt, input logic [63:0] a,
                           input logic [63:0] b, input logic [63:0] lr, input logic [4:0] lf);
    cycle(1, 0, 0, 0, iop, ifmt, a, b, 1, lr, lf);
  endtask

  initial begin
    reset = 1'b1; v = 1'b0; poison = 1'b0; flush = 1'b0;
    op = 4'd0; fmt = 1'b0; rs1 = '0; rs2 = '0;

    // Reset state.
    cycle(0, 0, 0, 1, 4'd0, 1'b0, 64'h0, 64'h0, 0, 64'h0, 5'h0);
    cycle(1, 0, 0, 1, 4'd1, 1'b1, 64'h3FF0000000000000, 64'h0, 0, 64'h0, 5'h0);
    idle();

    // Directed values, issued back to back.
    issue_lit(4'd1, 1'b1, 64'h3FF0000000000000, 64'h3FF0000000000000,
              64'hBFF0000000000000, 5'b00000);
    issue_lit(4'd3, 1'b1, 64'h7FF0000000000001, 64'hC000000000000000,
              64'hC000000000000000, 5'b10000);
    issue_lit(4'd4, 1'b1, 64'h7FF8000000000000, 64'h7FF8000000000001,
              64'h7FF8000000000000, 5'b00000);
    issue_lit(4'd6, 1'b0, 64'hFFFFFFFF3F800000, 64'h0000000040000000, 64'h0, 5'b10000);
    issue_lit(4'd5, 1'b0, 64'hFFFFFFFF3F800000, 64'h0000000040000000, 64'h0, 5'b00000);
    issue_lit(4'd8, 1'b1, 64'h8000000000000000, 64'h0, 64'h8, 5'b00000);
    issue_lit(4'd9, 1'b0, 64'h12345678BF800000, 64'h0, 64'hFFFFFFFFBF800000, 5'b00000);
    issue_lit(4'd3, 1'b1, 64'h0000000000000000, 64'h8000000000000000,
              64'h8000000000000000, 5'b00000);
    issue_lit(4'd4, 1'b0, 64'hFFFFFFFF80000000, 64'hFFFFFFFF00000000,
              64'hFFFFFFFF00000000, 5'b00000);
    issue_lit(4'd7, 1'b1, 64'h8000000000000000, 64'h0000000000000000, 64'h1, 5'b00000);
    issue_lit(4'd10, 1'b0, 64'hDEADBEEF12345678, 64'h0, 64'hFFFFFFFF12345678, 5'b00000);
    issue_lit(4'd12, 1'b1, 64'h3FF0000000000000, 64'h3FF0000000000000, 64'h0, 5'b00000);
    repeat (5) idle();

    // Poison drops only the op it accompanies.
    issue(4'd0, 1'b1, 64'h4000000000000000, 64'h8000000000000000);
    cycle(1, 1, 0, 0, 4'd8, 1'b1, 64'h7FF0000000000000, 64'h0, 0, 64'h0, 5'h0);
    issue(4'd2, 1'b0, 64'hFFFFFFFFBF800000, 64'hFFFFFFFF80000000);
    repeat (5) idle();

    // Four consecutive ops with flush on the third issue cycle.
    issue(4'd9, 1'b1, 64'h1111111111111111, 64'h0);
    issue(4'd9, 1'b1, 64'h2222222222222222, 64'h0);
    cycle(1, 0, 1, 0, 4'd9, 1'b1, 64'h3333333333333333, 64'h0, 0, 64'h0, 5'h0);
    issue_lit(4'd9, 1'b1, 64'h4444444444444444, 64'h0, 64'h4444444444444444, 5'b00000);
    repeat (5) idle();

    // Reset with two ops in flight, then a fresh issue.
    issue(4'd6, 1'b1, 64'h7FF8000000000000, 64'h0);
    issue(4'd10, 1'b1, 64'h5555555555555555, 64'h0);
    cycle(1, 0, 1, 1, 4'd9, 1'b1, 64'h6666666666666666, 64'h0, 0, 64'h0, 5'h0);
    repeat (5) idle();
    issue_lit(4'd8, 1'b0, 64'hFFFFFFFF7F800001, 64'h0, 64'h100, 5'b00000);
    repeat (5) idle();

    // Randomized traffic across all ops, formats and control inputs.
    for (int i = 0; i < 500; i++) begin
      logic [63:0] a, b;
      bit f;
      f = 1'($urandom_range(0, 1));
      a = rand_opnd(f);
      b = ($urandom_range(0, 7) == 0) ? a : rand_opnd(f);
      cycle($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 29) == 0, $urandom_range(0, 99) == 0,
            4'($urandom_range(0, 15)), f, a, b, 0, 64'h0, 5'h0);
    end
    repeat (6) idle();

    if (n_fail != 0) $display("%0d checks did not match", n_fail);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bp_be_pipe_fp_misc.md
# bp_be_pipe_fp_misc

Parametrised, fully pipelined floating-point "misc" pipe for the BlackParrot backend. It executes non-arithmetic RISC-V F/D operations: sign injection, min/max, compares, classify and raw moves. Results and exception flags are produced a fixed `latency_p` cycles after issue. It replaces the stub FP pipe, whose output is a constant zero. The block sits beside the integer pipes and feeds the writeback/commit stage.

## Interface
- `latency_p`, default 2: issue-to-result latency in cycles; legal range 1..4.
- `dword_width_p`, default 64: operand and result width; fixed at 64, FLEN=64.
- `clk_i`  in  1: clock.
- `reset_i`  in  1: reset, synchronous, active-high.
- `v_i`  in  1: issue valid; no backpressure, one op accepted per cycle.
- `op_i`  in  4: 0 FSGNJ, 1 FSGNJN, 2 FSGNJX, 3 FMIN, 4 FMAX, 5 FEQ, 6 FLT, 7 FLE, 8 FCLASS, 9 FMV.X, 10 FMV.F; 11-15 reserved.
- `fmt_i`  in  1: 0 single (NaN-boxed), 1 double.
- `rs1_i`, `rs2_i`  in  64: source operands (FMV.F uses `rs1_i` as integer).
- `poison_i`  in  1: suppresses the op issued this cycle.
- `flush_i`  in  1: kills every in-flight op.
- `v_o`  out  1: result valid.
- `result_o`  out  64: result.
- `fflags_o`  out  5: {NV,DZ,OF,UF,NX}; only NV is ever set.

## Operation
- Stage 0 decodes and computes combinationally. `latency_p` register stages follow, each holding {valid, result, fflags}.
- A stage captures data only when its incoming valid bit is 1. `result_o` and `fflags_o` are forced to 0 whenever `v_o`=0.
- Single-precision operand unboxing:
  - Valid box: `rs[63:32]`==32'hFFFFFFFF.
  - Invalid box: the operand is treated as canonical qNaN 32'h7FC00000.
- Single-precision FP results (FSGNJ*, FMIN/FMAX, FMV.F) are NaN-boxed, upper 32 bits all ones.
- Sign injection:
  - The result takes rs1 magnitude with sign = rs2 sign (J), ~rs2 sign (JN), or rs1^rs2 sign (JX).
  - No flags; NaNs pass through unmodified.
- FMIN/FMAX:
  - −0 orders below +0.
  - One NaN operand: the result is the other operand.
  - Both NaN: the result is canonical NaN (D 64'h7FF8000000000000, S 64'hFFFFFFFF7FC00000).
  - NV=1 if either operand is sNaN.
- FEQ/FLT/FLE:
  - Result is 64-bit zero-extended 0/1; any NaN operand gives 0.
  - FEQ sets NV only on sNaN. FLT/FLE set NV on any NaN.
  - +0 == −0.
- FCLASS: 10-bit one-hot, zero-extended. Bits 0 −inf, 1 −normal, 2 −subnormal, 3 −0, 4 +0, 5 +subnormal, 6 +normal, 7 +inf, 8 sNaN, 9 qNaN.
- FMV.X: D passes all bits; S sign-extends `rs1_i[31:0]` with no unboxing check.
- FMV.F: D passes all bits; S gives {32'hFFFFFFFF, `rs1_i[31:0]`}.
- Reserved op: `v_o` still asserts, with `result_o`=0 and `fflags_o`=0.

## Timing
- Op accepted at edge N (`v_i`=1, `poison_i`=0, `flush_i`=0): `v_o`=1 during the cycle after edge N+`latency_p`−1, i.e. `latency_p` cycles later.
- Back-to-back issue gives back-to-back results in order; throughput is 1 per cycle.
- `flush_i`=1 at an edge:
  - All stage valid bits clear.
  - An op issued in the same cycle is also dropped.
  - An op issued the next cycle proceeds normally.
- `poison_i`=1 drops only the current issue. In-flight ops are unaffected.
- Reset:
  - All valid bits are 0 and the data registers are 0.
  - `v_o`=0, `result_o`=0, `fflags_o`=0 from the first edge with `reset_i`=1.
  - Reset mid-operation discards all in-flight ops.
  - Reset has priority over `v_i` and `flush_i`.

## Test plan
- D FSGNJN, `rs1`=64'h3FF0000000000000, `rs2`=64'h3FF0000000000000, `latency_p`=2 → 2 cycles later `v_o`=1, `result_o`=64'hBFF0000000000000, `fflags_o`=0.
- D FMIN, `rs1`=64'h7FF0000000000001 (sNaN), `rs2`=64'hC000000000000000 → `result_o`=64'hC000000000000000, `fflags_o`=5'b10000. FMAX of two qNaNs → 64'h7FF8000000000000, `fflags_o`=0.
- S FLT, `rs1`=64'hFFFFFFFF3F800000, `rs2`=64'h00000000_40000000 (bad box) → `result_o`=0, NV=1. S FEQ of the same operands → `result_o`=0, NV=0.
- FCLASS D −0 (64'h8000000000000000) → `result_o`=64'h8. S FMV.X of 64'hxxxxxxxx_BF800000 → `result_o`=64'hFFFFFFFFBF800000.
- Issue 4 consecutive ops with `latency_p`=3 and assert `flush_i` on the 3rd issue cycle → no `v_o` for ops 1-3; op 4 appears 3 cycles after its issue.
- Assert `reset_i` with 2 ops in flight, then release → `v_o`, `result_o`, `fflags_o` stay 0 until a new issue; the sequence is repeated for each `latency_p` in 1..4.
